input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Parametrised conditioning front-end for all slow asynchronous inputs on the clk27 domain: buttons, HDMI TX mode/interrupt and similar.
- Per channel it provides:
  - a configurable-depth synchroniser;
  - an optional debounce filter;
  - sticky rise/fall event flags with a CPU acknowledge handshake.
- It also generates the CPU reset pulse, with programmable length and a software re-trigger.
- Sits between the board pins and the sys PIO inputs, replacing the hand-coded two-flop synchronisers and the fixed reset counter.

Parameters:
- N_IN, 4, number of input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (2..4).
- DEB_W, 16, debounce counter width.
- DEB_CYCLES, 27000, consecutive clk27 cycles a new level must persist before it is accepted (1..2^DEB_W-1). Default is 1 ms at 27 MHz.
- INIT_VAL, {N_IN{1'b0}}, reset value of synchroniser flops and stable outputs, per channel.
- RST_W, 4, reset pulse counter width.
- RST_CYCLES, 8, length of the rst_pulse_n low phase after release or re-trigger (1..2^RST_W-1).

Ports:
- clk27  in  1  system clock, 27 MHz.
- reset  in  1  synchronous, active-high reset.
- async_in  in  N_IN  raw asynchronous inputs.
- deb_bypass  in  N_IN  per channel: 1 = skip debounce (stable follows the synchronised value). Must be quasi-static.
- evt_ack  in  N_IN  per channel: pulse 1 to clear both event flags of that channel.
- rst_req  in  1  pulse that re-triggers the reset pulse.
- stable_out  out  N_IN  conditioned level.
- rise_evt  out  N_IN  sticky flag: a 0->1 transition was seen on stable_out.
- fall_evt  out  N_IN  sticky flag: a 1->0 transition was seen on stable_out.
- evt_pend  out  1  OR of all rise_evt and fall_evt bits.
- rst_pulse_n  out  1  active-low reset for downstream logic (CPU).

Behaviour:
- Reset (reset=1):
  - sync chains and stable_out load INIT_VAL;
  - debounce counters load 0;
  - rise_evt, fall_evt, evt_pend load 0;
  - reset counter loads 0 and rst_pulse_n loads 0.
- Synchroniser: plain shift chain of SYNC_STAGES flops. sync = last stage. No logic between stages.
- Debounce, per channel, one counter cnt[DEB_W]:
  - sync == stable: cnt <= 0.
  - sync != stable and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - sync != stable and cnt == DEB_CYCLES-1: stable <= sync, cnt <= 0.
  - Any bounce back to the stable level restarts the count from 0.
  - DEB_CYCLES=1 gives 1 extra cycle of latency.
- Bypass (deb_bypass=1): stable <= sync every cycle and cnt held at 0. Toggling bypass mid-count restarts filtering cleanly.
- Latency from async_in edge to stable_out:
  - debounced: SYNC_STAGES + DEB_CYCLES cycles (±1 for metastability);
  - bypass: SYNC_STAGES + 1 cycles.
- Events, registered from stable:
  - stable changes 0->1 in a cycle: rise_evt sets next cycle;
  - stable changes 1->0: fall_evt sets next cycle.
  - Flags stay set until evt_ack for that channel.
  - evt_ack and a new set in the same cycle: set wins, so no event is lost.
  - Ack of a clear channel: no effect.
- evt_pend is registered and is the OR of the next-state flags, so it is cycle-aligned with the flags.
- Reset generator, counter rc[RST_W]:
  - rc < RST_CYCLES: rc <= rc+1, rst_pulse_n = 0.
  - rc == RST_CYCLES: rst_pulse_n = 1, counter holds.
  - rst_req=1 (any state): rc <= 0, rst_pulse_n = 0 next cycle.
  - After reset release, rst_pulse_n is low for exactly RST_CYCLES cycles, then high.
  - rst_req asserted continuously holds rst_pulse_n low.
- The generator is independent of the input channels. Its pulse does not clear flags; only reset does.
- Reset mid-operation: all state is reinitialised in the same edge. No partial debounce carries over.

Decomposition:
- Shared package ic_pkg holds:
  - default constants: DEB_CYCLES_1MS=27000, SYNC_STAGES_DEF=2, RST_CYCLES_DEF=8;
  - a localparam helper for counter width, clog2(DEB_CYCLES+1).
- Natural sub-module input_debounce_ch: one channel covering synchroniser, debounce counter and edge/flag logic. It is instantiated N_IN times by a generate loop.
- Top level holds the evt_pend OR and the reset generator.

Test Plan:
- Reset release (bench params DEB_CYCLES=4, SYNC_STAGES=2, RST_CYCLES=8), reset=1 then 0 -> rst_pulse_n low exactly 8 cycles then 1; stable_out=INIT_VAL=0; no flags set.
- Clean edge: async_in[0] 0->1 and held -> stable_out[0]=1 after 2+4 cycles; rise_evt[0]=1 one cycle later; evt_pend=1; pulse evt_ack[0] -> rise_evt[0]=0, evt_pend=0.
- Bounce: async_in[1] high 3 cycles, low 1, high 6 -> stable_out[1] never toggles during the bounce; it goes 1 exactly 4 cycles after the final rise reaches sync; only one rise_evt.
- Bypass: deb_bypass[2]=1, 1-cycle-wide pulse on async_in[2] -> stable_out[2] high for 1 cycle at latency 3; rise_evt[2] and fall_evt[2] both set.
- Ack collision: evt_ack[0] asserted in the same cycle a new fall on ch0 sets its flag -> fall_evt[0]=1 afterwards; the earlier rise_evt[0] is cleared.
- rst_req pulse with rst_pulse_n=1 -> rst_pulse_n low 8 cycles then 1; a second rst_req at cycle 5 extends the low phase to 5+8 cycles; stable_out and flags are unchanged.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants, types and helpers for the input conditioner.
// Anything that both the top level and the per-channel logic need lives here.
package ic_pkg;

  // Debounce length giving 1 ms at the 27 MHz system clock.
  localparam int DEB_CYCLES_1MS  = 27000;

  // Two flops is enough for slow board-level inputs at 27 MHz.
  localparam int SYNC_STAGES_DEF = 2;

  // Default low time of the CPU reset pulse, in clk27 cycles.
  localparam int RST_CYCLES_DEF  = 8;

  // Per-channel result bundle collected by the top level.
  typedef struct packed {
    logic stable;
    logic rise;
    logic fall;
    logic rise_nxt;
    logic fall_nxt;
  } ch_status_t;

  // Smallest counter width able to hold the value 'cycles'.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundles the pin-side inputs and the CPU-side outputs of the conditioner.
// master is the side that drives the raw inputs and consumes the results,
// slave is the conditioner itself.
interface input_conditioner_if #(
  parameter int N_IN = 4
);

  logic [N_IN-1:0] async_in;
  logic [N_IN-1:0] deb_bypass;
  logic [N_IN-1:0] evt_ack;
  logic            rst_req;

  logic [N_IN-1:0] stable_out;
  logic [N_IN-1:0] rise_evt;
  logic [N_IN-1:0] fall_evt;
  logic            evt_pend;
  logic            rst_pulse_n;

  modport master (
    output async_in,
    output deb_bypass,
    output evt_ack,
    output rst_req,
    input  stable_out,
    input  rise_evt,
    input  fall_evt,
    input  evt_pend,
    input  rst_pulse_n
  );

  modport slave (
    input  async_in,
    input  deb_bypass,
    input  evt_ack,
    input  rst_req,
    output stable_out,
    output rise_evt,
    output fall_evt,
    output evt_pend,
    output rst_pulse_n
  );

endinterface

// File: rtl/input_conditioner_debounce_ch.sv
// One conditioning channel: synchroniser chain, debounce counter and the
// sticky rise/fall event flags with their acknowledge handshake.
module input_debounce_ch
  import ic_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   DEB_CYCLES  = DEB_CYCLES_1MS,
  parameter int   DEB_W       = cnt_width(DEB_CYCLES),
  parameter logic INIT_VAL    = 1'b0
) (
  input  logic clk27,
  input  logic reset,
  input  logic async_in,
  input  logic deb_bypass,
  input  logic evt_ack,
  output logic stable_out,
  output logic rise_evt,
  output logic fall_evt,
  output logic rise_nxt,
  output logic fall_nxt
);

  // Counter value on which the new level is accepted.
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [DEB_W-1:0]       cnt_q;
  logic                   stable_d;
  logic                   rise_set;
  logic                   fall_set;

  // Plain shift chain; the last stage is the only one used downstream.
  always_ff @(posedge clk27) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{INIT_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Accept a new level only after it has persisted for DEB_CYCLES samples;
  // any return to the current level, or bypass, restarts the count.
  always_ff @(posedge clk27) begin
    if (reset) begin
      stable_out <= INIT_VAL;
      cnt_q      <= '0;
    end else if (deb_bypass) begin
      stable_out <= sync_lvl;
      cnt_q      <= '0;
    end else if (sync_lvl == stable_out) begin
      cnt_q      <= '0;
    end else if (cnt_q >= CNT_LAST) begin
      stable_out <= sync_lvl;
      cnt_q      <= '0;
    end else begin
      cnt_q      <= cnt_q + 1'b1;
    end
  end

  // Previous stable level, used to spot transitions of stable_out.
  always_ff @(posedge clk27) begin
    if (reset) begin
      stable_d <= INIT_VAL;
    end else begin
      stable_d <= stable_out;
    end
  end

  // Next-state flags; a fresh set overrides an acknowledge in the same cycle
  // so an event arriving during the ack is never lost.
  always_comb begin
    rise_set = stable_out & ~stable_d;
    fall_set = ~stable_out & stable_d;
    rise_nxt = rise_set | (rise_evt & ~evt_ack);
    fall_nxt = fall_set | (fall_evt & ~evt_ack);
  end

  // Sticky flags cleared only by acknowledge or reset.
  always_ff @(posedge clk27) begin
    if (reset) begin
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      rise_evt <= rise_nxt;
      fall_evt <= fall_nxt;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditioning front-end for the slow asynchronous board inputs.
// Instantiates one channel per input, combines the event flags into a single
// pending indication and generates the programmable CPU reset pulse.
module input_conditioner
  import ic_pkg::*;
#(
  parameter int              N_IN        = 4,
  parameter int              SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int              DEB_W       = 16,
  parameter int              DEB_CYCLES  = DEB_CYCLES_1MS,
  parameter logic [N_IN-1:0] INIT_VAL    = {N_IN{1'b0}},
  parameter int              RST_W       = 4,
  parameter int              RST_CYCLES  = RST_CYCLES_DEF
) (
  input  logic                clk27,
  input  logic                reset,
  input_conditioner_if.slave  bus
);

  // Counter value at which the reset pulse is released.
  localparam logic [RST_W-1:0] RC_END = RST_W'(RST_CYCLES);

  ch_status_t       status [N_IN];
  logic [N_IN-1:0]  stable_v;
  logic [N_IN-1:0]  rise_v;
  logic [N_IN-1:0]  fall_v;
  logic [N_IN-1:0]  rise_nxt_v;
  logic [N_IN-1:0]  fall_nxt_v;
  logic [RST_W-1:0] rc_q;
  logic             rst_pulse_q;
  logic             evt_pend_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    input_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES),
      .DEB_W       (DEB_W),
      .INIT_VAL    (INIT_VAL[i])
    ) u_ch (
      .clk27      (clk27),
      .reset      (reset),
      .async_in   (bus.async_in[i]),
      .deb_bypass (bus.deb_bypass[i]),
      .evt_ack    (bus.evt_ack[i]),
      .stable_out (status[i].stable),
      .rise_evt   (status[i].rise),
      .fall_evt   (status[i].fall),
      .rise_nxt   (status[i].rise_nxt),
      .fall_nxt   (status[i].fall_nxt)
    );
  end

  // Flatten the per-channel status into the output vectors.
  always_comb begin
    stable_v   = '0;
    rise_v     = '0;
    fall_v     = '0;
    rise_nxt_v = '0;
    fall_nxt_v = '0;
    for (int i = 0; i < N_IN; i++) begin
      stable_v[i]   = status[i].stable;
      rise_v[i]     = status[i].rise;
      fall_v[i]     = status[i].fall;
      rise_nxt_v[i] = status[i].rise_nxt;
      fall_nxt_v[i] = status[i].fall_nxt;
    end
  end

  // Pending indication built from the next-state flags so that it changes
  // in the same cycle as the flags themselves.
  always_ff @(posedge clk27) begin
    if (reset) begin
      evt_pend_q <= 1'b0;
    end else begin
      evt_pend_q <= |(rise_nxt_v | fall_nxt_v);
    end
  end

  // Reset pulse: count up to RC_END with the output low, then hold high;
  // a software request restarts the low phase from any state.
  always_ff @(posedge clk27) begin
    if (reset) begin
      rc_q        <= '0;
      rst_pulse_q <= 1'b0;
    end else if (bus.rst_req) begin
      rc_q        <= '0;
      rst_pulse_q <= 1'b0;
    end else if (rc_q < RC_END) begin
      rc_q        <= rc_q + 1'b1;
      rst_pulse_q <= ((rc_q + 1'b1) == RC_END);
    end else begin
      rst_pulse_q <= 1'b1;
    end
  end

  assign bus.stable_out  = stable_v;
  assign bus.rise_evt    = rise_v;
  assign bus.fall_evt    = fall_v;
  assign bus.evt_pend    = evt_pend_q;
  assign bus.rst_pulse_n = rst_pulse_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus drives the bus and pushes
// the reference expectation for the following edge, a monitor pops and
// compares after every clock edge.
module tb_input_conditioner;

  localparam int N     = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int DEB_W = 16;
  localparam int RST   = 8;
  localparam int RST_W = 4;
  localparam int PAD   = SYNC + DEB + 2;
  localparam logic [N-1:0] INIT = '0;

  typedef struct {
    logic [N-1:0] stable;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         pend;
    logic         rstn;
  } exp_t;

  logic clk27;
  logic reset;

  input_conditioner_if #(.N_IN(N)) ifc ();

  input_conditioner #(
    .N_IN        (N),
    .SYNC_STAGES (SYNC),
    .DEB_W       (DEB_W),
    .DEB_CYCLES  (DEB),
    .INIT_VAL    (INIT),
    .RST_W       (RST_W),
    .RST_CYCLES  (RST)
  ) dut (
    .clk27 (clk27),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk27 = 1'b0;
  always #5 clk27 = ~clk27;

  exp_t         sb [$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           started  = 0;

  // Reference model state: histories of samples per edge, newest last.
  logic [N-1:0] async_h  [$];
  logic [N-1:0] sync_h   [$];
  logic [N-1:0] stable_h [$];
  logic [N-1:0] rise_m;
  logic [N-1:0] fall_m;
  int           edge_n   = 0;
  int           last_req = 0;

  logic [N-1:0] a_cur;
  logic [N-1:0] byp_cur;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp_v);
    end
  endtask

  function automatic void modelReset();
    async_h.delete();
    sync_h.delete();
    stable_h.delete();
    for (int i = 0; i < PAD; i++) begin
      async_h.push_back(INIT);
      sync_h.push_back(INIT);
      stable_h.push_back(INIT);
    end
    rise_m   = '0;
    fall_m   = '0;
    last_req = edge_n;
  endfunction

  // Behavioural rules: sync is the input delayed SYNC edges; stable takes a
  // new level once the last DEB synchronised samples all show it; events come
  // from the stable history one edge late; the reset pulse is high once RST
  // edges have passed since the last reset or request.
  function automatic exp_t modelStep(input logic rst, input logic [N-1:0] a,
                                     input logic [N-1:0] byp, input logic [N-1:0] ack,
                                     input logic req);
    exp_t         e;
    logic [N-1:0] s_prev, s_new, st_prev, st_prev2, st_new;
    edge_n++;
    if (rst) begin
      modelReset();
      e.stable = INIT; e.rise = '0; e.fall = '0; e.pend = 1'b0; e.rstn = 1'b0;
      return e;
    end
    async_h.push_back(a);
    s_new    = async_h[async_h.size() - SYNC];
    s_prev   = sync_h[sync_h.size() - 1];
    st_prev  = stable_h[stable_h.size() - 1];
    st_prev2 = stable_h[stable_h.size() - 2];
    for (int c = 0; c < N; c++) begin
      if (byp[c]) begin
        st_new[c] = s_prev[c];
      end else begin
        bit all_new = 1;
        for (int j = 1; j <= DEB; j++)
          if (sync_h[sync_h.size() - j][c] == st_prev[c]) all_new = 0;
        st_new[c] = all_new ? ~st_prev[c] : st_prev[c];
      end
    end
    rise_m = (st_prev & ~st_prev2) | (rise_m & ~ack);
    fall_m = (~st_prev & st_prev2) | (fall_m & ~ack);
    sync_h.push_back(s_new);
    stable_h.push_back(st_new);
    while (async_h.size() > 2 * PAD) async_h.pop_front();
    while (sync_h.size() > 2 * PAD) sync_h.pop_front();
    while (stable_h.size() > 2 * PAD) stable_h.pop_front();
    if (req) last_req = edge_n;
    e.stable = st_new;
    e.rise   = rise_m;
    e.fall   = fall_m;
    e.pend   = |(rise_m | fall_m);
    e.rstn   = !req && ((edge_n - last_req) >= RST);
    return e;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [N-1:0] a, input logic [N-1:0] byp,
                               input logic [N-1:0] ack, input logic req);
    @(negedge clk27);
    reset          = rst;
    ifc.async_in   = a;
    ifc.deb_bypass = byp;
    ifc.evt_ack    = ack;
    ifc.rst_req    = req;
    sb.push_back(modelStep(rst, a, byp, ack, req));
    started = 1;
  endtask

  // Monitor: one expectation per clock edge.
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(posedge clk27);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("stable_out",  32'(ifc.stable_out), 32'(e.stable));
        checkOutput("rise_evt",    32'(ifc.rise_evt),   32'(e.rise));
        checkOutput("fall_evt",    32'(ifc.fall_evt),   32'(e.fall));
        checkOutput("evt_pend",    32'(ifc.evt_pend),   32'(e.pend));
        checkOutput("rst_pulse_n", 32'(ifc.rst_pulse_n), 32'(e.rstn));
      end
    end
  end

  initial begin
    reset          = 1'b1;
    ifc.async_in   = '0;
    ifc.deb_bypass = '0;
    ifc.evt_ack    = '0;
    ifc.rst_req    = 1'b0;
    a_cur          = '0;
    byp_cur        = '0;
    modelReset();

    // Reset and release: pulse stays low for RST edges, no flags.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, '0, '0, '0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0);

    // Clean rising edge on channel 0, then acknowledge.
    a_cur[0] = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, a_cur, '0, '0, 1'b0);
    applyStimulus(1'b0, a_cur, '0, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, a_cur, '0, '0, 1'b0);

    // Bouncing input on channel 1: high 3, low 1, high 6, then held.
    for (int i = 0; i < 14; i++) begin
      a_cur[1] = !(i >= 3 && i < 4);
      applyStimulus(1'b0, a_cur, '0, '0, 1'b0);
    end

    // Bypassed single-cycle pulse on channel 2.
    byp_cur[2] = 1'b1;
    applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b0);
    a_cur[2] = 1'b1;
    applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b0);
    a_cur[2] = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b0);
    applyStimulus(1'b0, a_cur, byp_cur, 4'b0110, 1'b0);

    // Channel 0 falls; ack arrives on the very edge its fall flag sets.
    // Re-raise first so rise_evt[0] is pending when the fall lands.
    a_cur[0] = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b0);
    a_cur[0] = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b0);
    a_cur[0] = 1'b0;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, a_cur, byp_cur, (i == 6) ? 4'b0001 : 4'b0000, 1'b0);

    // Software reset request, then a second one five edges later.
    applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b0);
    applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b0);

    // Randomised traffic: slow toggles, random acks, requests, bypass flips
    // and occasional mid-operation resets.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] ack_r;
      logic         rst_r, req_r;
      for (int c = 0; c < N; c++)
        if ($urandom_range(9) == 0) a_cur[c] = ~a_cur[c];
      if ($urandom_range(199) == 0) byp_cur[$urandom_range(N-1)] ^= 1'b1;
      ack_r = N'($urandom) & N'($urandom) & N'($urandom);
      req_r = ($urandom_range(49) == 0);
      rst_r = ($urandom_range(499) == 0);
      applyStimulus(rst_r, a_cur, byp_cur, ack_r, req_r);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, a_cur, byp_cur, '0, 1'b0);

    @(posedge clk27);
    #2;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
